// File: rtl/sparc_control_unit.sv
// Moore control FSM for the multi-cycle SPARC datapath. `SPARC_MOC_TIMEOUT_EN enables a
// memory-wait watchdog that traps to ILLEGAL. The access-size port is Type (type is reserved).
module sparc_control_unit #(
  parameter int MOC_TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [31:0] IR,
  input  logic        MOC,
  input  logic        BCOND,
  input  logic        TCOND,
  output logic [5:0]  OpXX,
  output logic        IR_Ld,
  output logic        MAR_Ld,
  output logic        MDR_Ld,
  output logic        WIM_Ld,
  output logic        TBR_Ld,
  output logic        TTR_Ld,
  output logic        PC_Ld,
  output logic        NPC_Ld,
  output logic        nPC_Clr,
  output logic        PSR_Ld,
  output logic        FR_Ld,
  output logic        Register_Windows_Enable,
  output logic        RF_Load_Enable,
  output logic        RF_Clear_Enable,
  output logic        RW,
  output logic        MOV,
  output logic [1:0]  Type,
  output logic [1:0]  MA,
  output logic [1:0]  MB,
  output logic [1:0]  MNP,
  output logic [1:0]  MP,
  output logic [1:0]  MSc,
  output logic        MC,
  output logic        MF,
  output logic        MM,
  output logic        MR,
  output logic        MOP,
  output logic        MSa,
  output logic [7:0]  Trap_Code,
  output logic [5:0]  State
);

  typedef enum logic [5:0] {
    S_RESET    = 6'd0,
    S_FETCH1   = 6'd1,
    S_FETCH2   = 6'd2,
    S_FETCH3   = 6'd3,
    S_DECODE   = 6'd4,
    S_SETHI    = 6'd10,
    S_ALU      = 6'd11,
    S_BR_TAKEN = 6'd12,
    S_BR_NOT   = 6'd13,
    S_LOAD1    = 6'd14,
    S_LOAD2    = 6'd15,
    S_LOAD3    = 6'd16,
    S_STORE1   = 6'd17,
    S_STORE2   = 6'd18,
    S_CALL     = 6'd20,
    S_TRAP     = 6'd30,
    S_ILLEGAL  = 6'd31
  } state_t;

  typedef struct packed {
    logic [5:0] opxx;
    logic       ir_ld, mar_ld, mdr_ld, wim_ld, tbr_ld, ttr_ld;
    logic       pc_ld, npc_ld, npc_clr, psr_ld, fr_ld;
    logic       rwe, rf_ld, rf_clr, rw, mov;
    logic [1:0] typ, ma, mb, mnp, mp, msc;
    logic       mc, mf, mm, mr, mop, msa;
    logic [7:0] trap_code;
  } ctrl_t;

  state_t      r_state;
  ctrl_t       r_ctrl;
  state_t      w_next_state;
  logic [7:0]  w_illegal_code;

  logic [1:0]  w_op;
  logic [2:0]  w_op2;
  logic [5:0]  w_op3;
  logic        w_i;
  logic        w_unused_ir;

  assign w_op        = IR[31:30];
  assign w_op2       = IR[24:22];
  assign w_op3       = IR[24:19];
  assign w_i         = IR[13];
  assign w_unused_ir = ^{IR[28:25], IR[18:14], IR[12:7]};

  // Control word for a given state; outputs are registered from the state being entered.
  function automatic ctrl_t decode_ctrl(input state_t st, input logic [5:0] op3,
                                        input logic i, input logic annul,
                                        input logic [6:0] trap_num,
                                        input logic [7:0] illegal_code);
    ctrl_t c;
    c = '0;
    case (st)
      S_RESET: begin
        c.rf_clr = 1'b1; c.pc_ld = 1'b1; c.npc_ld = 1'b1; c.mr = 1'b1; c.mnp = 2'b11;
      end
      S_FETCH1: begin
        c.mar_ld = 1'b1; c.mb = 2'b10; c.mop = 1'b1; c.opxx = 6'b010001;
      end
      S_FETCH2: begin
        c.rw = 1'b1; c.mov = 1'b1; c.typ = 2'b10;
      end
      S_FETCH3: begin
        c.ir_ld = 1'b1; c.pc_ld = 1'b1; c.npc_ld = 1'b1; c.mnp = 2'b00;
      end
      S_ALU: begin
        c.rwe = 1'b1; c.rf_ld = 1'b1; c.opxx = op3; c.mb = {1'b0, i}; c.fr_ld = op3[4];
      end
      S_SETHI: begin
        c.rf_ld = 1'b1; c.mb = 2'b11; c.opxx = 6'b010001;
      end
      S_BR_TAKEN: begin
        c.npc_ld = 1'b1; c.mnp = 2'b01;
      end
      S_BR_NOT: begin
        c.pc_ld = annul; c.npc_ld = annul;
      end
      S_CALL: begin
        c.rf_ld = 1'b1; c.mc = 1'b1; c.npc_ld = 1'b1; c.mnp = 2'b10;
      end
      S_LOAD1: begin
        c.mar_ld = 1'b1; c.mb = {1'b0, i};
      end
      S_LOAD2: begin
        c.rw = 1'b1; c.mov = 1'b1; c.typ = op3[1:0];
      end
      S_LOAD3: begin
        c.rf_ld = 1'b1; c.mm = 1'b1;
      end
      S_STORE1: begin
        c.mar_ld = 1'b1; c.mdr_ld = 1'b1; c.mb = {1'b0, i};
      end
      S_STORE2: begin
        c.mov = 1'b1; c.typ = op3[1:0];
      end
      S_TRAP, S_ILLEGAL: begin
        c.ttr_ld = 1'b1; c.tbr_ld = 1'b1; c.psr_ld = 1'b1; c.pc_ld = 1'b1;
        c.npc_clr = 1'b1; c.mp = 2'b10;
        c.trap_code = (st == S_TRAP) ? (8'h80 | {1'b0, trap_num}) : illegal_code;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

`ifdef SPARC_MOC_TIMEOUT_EN
  localparam int CW = $clog2(MOC_TIMEOUT + 1);
  logic [CW-1:0] r_wait_cnt;
  logic          w_timeout;

  assign w_timeout = ((r_state == S_FETCH2) || (r_state == S_LOAD2) || (r_state == S_STORE2))
                     && !MOC && (r_wait_cnt == CW'(MOC_TIMEOUT - 1));
`else
  localparam int unused_moc_timeout = MOC_TIMEOUT;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_next_state   = r_state;
    w_illegal_code = 8'h02;
    case (r_state)
      S_RESET:  w_next_state = S_FETCH1;
      S_FETCH1: w_next_state = S_FETCH2;
      S_FETCH2: if (MOC) w_next_state = S_FETCH3;
      S_FETCH3: w_next_state = S_DECODE;
      S_DECODE: begin
        case (w_op)
          2'b01: w_next_state = S_CALL;
          2'b00: begin
            if (w_op2 == 3'b100)      w_next_state = S_SETHI;
            else if (w_op2 == 3'b010) w_next_state = BCOND ? S_BR_TAKEN : S_BR_NOT;
            else                      w_next_state = S_ILLEGAL;
          end
          2'b10: begin
            if (w_op3 == 6'b111010) w_next_state = TCOND ? S_TRAP : S_FETCH1;
            else                    w_next_state = S_ALU;
          end
          default: w_next_state = w_op3[2] ? S_STORE1 : S_LOAD1;
        endcase
      end
      S_LOAD1:  w_next_state = S_LOAD2;
      S_LOAD2:  if (MOC) w_next_state = S_LOAD3;
      S_STORE1: w_next_state = S_STORE2;
      S_STORE2: if (MOC) w_next_state = S_FETCH1;
      default:  w_next_state = S_FETCH1;
    endcase
`ifdef SPARC_MOC_TIMEOUT_EN
    if (w_timeout) begin
      w_next_state   = S_ILLEGAL;
      w_illegal_code = (r_state == S_FETCH2) ? 8'h01 : 8'h09;
    end
`endif
  end

  // NOTE: async reset forces the S0 control word at once, so MOV drops mid-access.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_RESET;
      r_ctrl  <= decode_ctrl(S_RESET, 6'd0, 1'b0, 1'b0, 7'd0, 8'd0);
`ifdef SPARC_MOC_TIMEOUT_EN
      r_wait_cnt <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep state and outputs updating together.
      r_state <= w_next_state;
      r_ctrl  <= decode_ctrl(w_next_state, w_op3, w_i, IR[29], IR[6:0], w_illegal_code);
`ifdef SPARC_MOC_TIMEOUT_EN
      r_wait_cnt <= (w_next_state == r_state) ? r_wait_cnt + 1'b1 : '0;
`endif
    end
  end

  assign OpXX                    = r_ctrl.opxx;
  assign IR_Ld                   = r_ctrl.ir_ld;
  assign MAR_Ld                  = r_ctrl.mar_ld;
  assign MDR_Ld                  = r_ctrl.mdr_ld;
  assign WIM_Ld                  = r_ctrl.wim_ld;
  assign TBR_Ld                  = r_ctrl.tbr_ld;
  assign TTR_Ld                  = r_ctrl.ttr_ld;
  assign PC_Ld                   = r_ctrl.pc_ld;
  assign NPC_Ld                  = r_ctrl.npc_ld;
  assign nPC_Clr                 = r_ctrl.npc_clr;
  assign PSR_Ld                  = r_ctrl.psr_ld;
  assign FR_Ld                   = r_ctrl.fr_ld;
  assign Register_Windows_Enable = r_ctrl.rwe;
  assign RF_Load_Enable          = r_ctrl.rf_ld;
  assign RF_Clear_Enable         = r_ctrl.rf_clr;
  assign RW                      = r_ctrl.rw;
  assign MOV                     = r_ctrl.mov;
  assign Type                    = r_ctrl.typ;
  assign MA                      = r_ctrl.ma;
  assign MB                      = r_ctrl.mb;
  assign MNP                     = r_ctrl.mnp;
  assign MP                      = r_ctrl.mp;
  assign MSc                     = r_ctrl.msc;
  assign MC                      = r_ctrl.mc;
  assign MF                      = r_ctrl.mf;
  assign MM                      = r_ctrl.mm;
  assign MR                      = r_ctrl.mr;
  assign MOP                     = r_ctrl.mop;
  assign MSa                     = r_ctrl.msa;
  assign Trap_Code               = r_ctrl.trap_code;
  assign State                   = r_state;

endmodule

// File: tb/tb_sparc_control_unit.sv
// Self-checking bench for sparc_control_unit: directed spec vectors, random instructions with
// random memory wait counts, checked against an instruction-level state-sequence model.
module tb_sparc_control_unit;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [31:0] IR;
  logic        MOC, BCOND, TCOND;
  logic [5:0]  OpXX;
  logic        IR_Ld, MAR_Ld, MDR_Ld, WIM_Ld, TBR_Ld, TTR_Ld, PC_Ld, NPC_Ld, nPC_Clr;
  logic        PSR_Ld, FR_Ld, Register_Windows_Enable, RF_Load_Enable, RF_Clear_Enable;
  logic        RW, MOV, MC, MF, MM, MR, MOP, MSa;
  logic [1:0]  Type, MA, MB, MNP, MP, MSc;
  logic [7:0]  Trap_Code;
  logic [5:0]  State;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [5:0] opxx;
    logic       ir_ld, mar_ld, mdr_ld, wim_ld, tbr_ld, ttr_ld;
    logic       pc_ld, npc_ld, npc_clr, psr_ld, fr_ld;
    logic       rwe, rf_ld, rf_clr, rw, mov;
    logic [1:0] typ, ma, mb, mnp, mp, msc;
    logic       mc, mf, mm, mr, mop, msa;
    logic [7:0] trap_code;
  } ctl_t;

  ctl_t obs;

  sparc_control_unit #(.MOC_TIMEOUT(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .IR(IR), .MOC(MOC), .BCOND(BCOND), .TCOND(TCOND),
    .OpXX(OpXX), .IR_Ld(IR_Ld), .MAR_Ld(MAR_Ld), .MDR_Ld(MDR_Ld), .WIM_Ld(WIM_Ld),
    .TBR_Ld(TBR_Ld), .TTR_Ld(TTR_Ld), .PC_Ld(PC_Ld), .NPC_Ld(NPC_Ld), .nPC_Clr(nPC_Clr),
    .PSR_Ld(PSR_Ld), .FR_Ld(FR_Ld), .Register_Windows_Enable(Register_Windows_Enable),
    .RF_Load_Enable(RF_Load_Enable), .RF_Clear_Enable(RF_Clear_Enable), .RW(RW), .MOV(MOV),
    .Type(Type), .MA(MA), .MB(MB), .MNP(MNP), .MP(MP), .MSc(MSc), .MC(MC), .MF(MF),
    .MM(MM), .MR(MR), .MOP(MOP), .MSa(MSa), .Trap_Code(Trap_Code), .State(State)
  );

  always #5 Clk = ~Clk;

  always_comb begin
    obs = '{opxx: OpXX, ir_ld: IR_Ld, mar_ld: MAR_Ld, mdr_ld: MDR_Ld, wim_ld: WIM_Ld,
            tbr_ld: TBR_Ld, ttr_ld: TTR_Ld, pc_ld: PC_Ld, npc_ld: NPC_Ld, npc_clr: nPC_Clr,
            psr_ld: PSR_Ld, fr_ld: FR_Ld, rwe: Register_Windows_Enable, rf_ld: RF_Load_Enable,
            rf_clr: RF_Clear_Enable, rw: RW, mov: MOV, typ: Type, ma: MA, mb: MB, mnp: MNP,
            mp: MP, msc: MSc, mc: MC, mf: MF, mm: MM, mr: MR, mop: MOP, msa: MSa,
            trap_code: Trap_Code};
  end

  // Control word the state table requires for a state, given the instruction in IR.
  function automatic ctl_t model_out(input int st, input logic [31:0] ir, input logic [7:0] ill);
    ctl_t e;
    logic [5:0] op3;
    op3 = ir[24:19];
    e = '0;
    case (st)
      0:  begin e.rf_clr = 1; e.pc_ld = 1; e.npc_ld = 1; e.mr = 1; e.mnp = 2'b11; end
      1:  begin e.mar_ld = 1; e.mb = 2'b10; e.mop = 1; e.opxx = 6'b010001; end
      2:  begin e.rw = 1; e.mov = 1; e.typ = 2'b10; end
      3:  begin e.ir_ld = 1; e.pc_ld = 1; e.npc_ld = 1; end
      10: begin e.rf_ld = 1; e.mb = 2'b11; e.opxx = 6'b010001; end
      11: begin e.rwe = 1; e.rf_ld = 1; e.opxx = op3; e.mb = ir[13] ? 2'b01 : 2'b00;
                e.fr_ld = op3[4]; end
      12: begin e.npc_ld = 1; e.mnp = 2'b01; end
      13: begin e.pc_ld = ir[29]; e.npc_ld = ir[29]; end
      14: begin e.mar_ld = 1; e.mb = ir[13] ? 2'b01 : 2'b00; end
      15: begin e.rw = 1; e.mov = 1; e.typ = op3[1:0]; end
      16: begin e.rf_ld = 1; e.mm = 1; end
      17: begin e.mar_ld = 1; e.mdr_ld = 1; e.mb = ir[13] ? 2'b01 : 2'b00; end
      18: begin e.mov = 1; e.typ = op3[1:0]; end
      20: begin e.rf_ld = 1; e.mc = 1; e.npc_ld = 1; e.mnp = 2'b10; end
      30, 31: begin
        e.ttr_ld = 1; e.tbr_ld = 1; e.psr_ld = 1; e.pc_ld = 1; e.npc_clr = 1; e.mp = 2'b10;
        e.trap_code = (st == 30) ? 8'(8'h80 + ir[6:0]) : ill;
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic check_cycle(input string tag, input int exp_st, input ctl_t exp_o);
    checks++;
    assert (State === 6'(exp_st)) else begin
      failures++;
      $error("FAIL %s state: got %0d want %0d", tag, State, exp_st);
    end
    checks++;
    assert (obs === exp_o) else begin
      failures++;
      $error("FAIL %s outputs(st%0d): got %h want %h", tag, exp_st, obs, exp_o);
    end
  endtask

  // Walks one instruction from FETCH1; assumes the bench sits at a negedge in S1.
  task automatic run_instr(input string tag, input logic [31:0] ir, input bit bc, input bit tc,
                           input int w1, input int w2);
    int q[$];
    logic [1:0] op;
    logic [5:0] op3;
    IR = ir; BCOND = bc; TCOND = tc;
    op = ir[31:30]; op3 = ir[24:19];
    q.push_back(1);
    repeat (w1 + 1) q.push_back(2);
    q.push_back(3);
    q.push_back(4);
    if (op == 2'b01) q.push_back(20);
    else if (op == 2'b00) begin
      if (ir[24:22] == 3'b100)      q.push_back(10);
      else if (ir[24:22] == 3'b010) q.push_back(bc ? 12 : 13);
      else                          q.push_back(31);
    end else if (op == 2'b10) begin
      if (op3 == 6'b111010) begin if (tc) q.push_back(30); end
      else q.push_back(11);
    end else if (op3[2]) begin
      q.push_back(17);
      repeat (w2 + 1) q.push_back(18);
    end else begin
      q.push_back(14);
      repeat (w2 + 1) q.push_back(15);
      q.push_back(16);
    end
    for (int k = 0; k < q.size(); k++) begin
      check_cycle(tag, q[k], model_out(q[k], ir, 8'h02));
      if (q[k] == 2 || q[k] == 15 || q[k] == 18)
        MOC = (k + 1 >= q.size()) ? 1'b1 : (q[k + 1] != q[k]);
      else
        MOC = 1'($urandom_range(0, 1));
      @(negedge Clk);
    end
  endtask

  function automatic logic [31:0] rand_ir(input int kind);
    logic [31:0] r;
    logic [5:0]  op3;
    logic [2:0]  op2;
    r = $urandom;
    case (kind)
      0: begin
        do op3 = 6'($urandom); while (op3 == 6'b111010);
        r[31:30] = 2'b10; r[24:19] = op3;
      end
      1: begin r[31:30] = 2'b00; r[24:22] = 3'b100; end
      2: begin r[31:30] = 2'b00; r[24:22] = 3'b010; end
      3: r[31:30] = 2'b01;
      4: begin r[31:30] = 2'b10; r[24:19] = 6'b111010; end
      5: begin r[31:30] = 2'b11; r[21] = 1'b0; end
      6: begin r[31:30] = 2'b11; r[21] = 1'b1; end
      default: begin
        do op2 = 3'($urandom); while (op2 == 3'b100 || op2 == 3'b010);
        r[31:30] = 2'b00; r[24:22] = op2;
      end
    endcase
    return r;
  endfunction

  initial begin
    Reset_n = 1'b0; IR = 32'h0; MOC = 1'b0; BCOND = 1'b0; TCOND = 1'b0;

    // Reset held from time zero, sampled mid-cycle.
    #12;
    check_cycle("reset", 0, model_out(0, IR, 8'h00));
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    run_instr("add",    32'h86006005, 1'b0, 1'b0, 0, 0);
    run_instr("bne_t",  32'h12800002, 1'b1, 1'b0, 0, 0);
    run_instr("bne_nt", 32'h12800002, 1'b0, 1'b0, 1, 0);
    run_instr("ld",     32'hC2006000, 1'b0, 1'b0, 0, 3);
    run_instr("ta_t",   32'h91D02005, 1'b0, 1'b1, 0, 0);
    run_instr("ta_nt",  32'h91D02005, 1'b0, 1'b0, 2, 0);
    run_instr("annul",  32'h32800002, 1'b0, 1'b0, 0, 0);
    run_instr("st",     32'hC2206004, 1'b0, 1'b0, 0, 2);

    for (int n = 0; n < 80; n++)
      run_instr($sformatf("rand%0d", n), rand_ir(int'($urandom_range(0, 7))),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));

    // Reset pulsed mid-access in FETCH2: MOV must drop at once.
    check_cycle("pre_rst", 1, model_out(1, IR, 8'h02));
    MOC = 1'b0;
    @(negedge Clk);
    check_cycle("pre_rst", 2, model_out(2, IR, 8'h02));
    #2 Reset_n = 1'b0;
    #1 check_cycle("mid_rst", 0, model_out(0, IR, 8'h00));
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    run_instr("post_rst", 32'h03000010, 1'b0, 1'b0, 0, 0);

`ifdef SPARC_MOC_TIMEOUT_EN
    IR = 32'h86006005;
    check_cycle("tmo", 1, model_out(1, IR, 8'h02));
    MOC = 1'b0;
    @(negedge Clk);
    for (int c = 0; c < 16; c++) begin
      check_cycle("tmo_wait", 2, model_out(2, IR, 8'h02));
      @(negedge Clk);
    end
    check_cycle("tmo_trap", 31, model_out(31, IR, 8'h01));
    @(negedge Clk);
    check_cycle("tmo_back", 1, model_out(1, IR, 8'h02));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
